uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU's data-memory bus, downstream of the core alongside the GPIO word. Store instructions push bytes into a small FIFO; a bit-serial engine emits 8N1 frames on `tx`. Gives programs a debug/console path beyond the single 32-bit `gpio` word and lets benches check output as a byte stream.

## Interface
- `DIVISOR`, 868: reset value of the baud divisor, in clk cycles per bit (100 MHz / 115200).
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `we`  in  1  write strobe, one transfer per cycle.
- `re`  in  1  read strobe.
- `addr`  in  2  word index: 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `tx`  out  1  serial line, idle high.
- `irq`  out  1  level interrupt = overflow | (txie & empty & ~busy).

## Operation
- DATA write: push `wdata[7:0]` if FIFO not full; if full, drop byte, set sticky `overflow`. DATA read returns 0.
- STATUS read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bit4 txie, bits[31:5] 0. STATUS write: bit3=1 clears overflow; bit4 loads txie.
- DIV: bits[15:0] divisor, upper bits read 0. Written 0 stored as 1. New value applies from next START; in-flight frame keeps its latched divisor.
- Reserved address: writes ignored, reads 0.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1; FIFO non-empty → pop, latch byte and divisor, → START.
  - START: `tx`=0 for div cycles → DATA, bit index 0.
  - DATA: `tx`=byte[idx], LSB first, div cycles each; after idx 7 → STOP.
  - STOP: `tx`=1 for div cycles; then FIFO non-empty → pop, → START (no idle gap), else → IDLE.
- Frame = 10·div cycles.
- Push/pop same edge: count unchanged; if FIFO full at sample, push rejected even with a simultaneous pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap; full/empty from separate count of log2+1 bits.

## Timing
- Reset values: `tx`=1, `rdata`=0, `irq`=0, FIFO empty, overflow=0, txie=0, div=DIVISOR, FSM IDLE. Reset mid-frame forces `tx`=1 immediately and discards FIFO contents.
- Read latency 1: `rdata` valid the cycle after `re`; holds last value when `re`=0. Read and write same cycle to STATUS returns pre-write value.
- Write at edge E0 into empty FIFO with FSM IDLE: pop at E1, `tx` falls after E1 (2 cycles write-to-start-bit).
- `tx` registered; no combinational path from bus inputs to `tx` or `irq`.
- `irq` registered, updates one cycle after the causing event.
- `busy` stays 1 through the last stop-bit cycle; deasserts the cycle FSM enters IDLE.

## Structure
- Shared package `mips_pkg`: register-offset constants (DATA/STATUS/DIV), STATUS bit positions, FSM state encoding.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty), reusable for a later RX block; bit engine and register file in top.

## Test plan
- Reset: hold `reset`=0 mid-frame → `tx`=1, STATUS reads 0x2, DIV reads DIVISOR.
- DIV=4, write DATA 0x55 → after 2 cycles `tx` shows 0,1,0,1,0,1,0,1,0,1 each 4 cycles (40 total), busy then empty=1.
- DIV=2, FIFO_DEPTH=8, write 10 bytes back-to-back → first 9 accepted (one popped at once), 10th dropped, overflow=1, `irq`=1; write STATUS 0x8 clears both.
- Three queued bytes 0xA5,0x00,0xFF at DIV=3 → frames contiguous, no idle between stop and next start, 90 cycles total.
- Write DIV=8 during a frame at DIV=4 → current frame stays 4 cycles/bit, next frame 8 cycles/bit.
- txie=1, single byte at DIV=1 → `irq` rises one cycle after FSM returns to IDLE; DIV write of 0 reads back 1.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared constants for the memory-mapped peripherals on the
//            data-memory bus (register offsets, STATUS bit positions, UART TX
//            state encoding).
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  // Word offsets of the UART TX register block
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // STATUS register bit positions
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_TXIE  = 4;

  // Bit-engine states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero would stall the bit counter; it is stored as one.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio_if : data-memory bus slice seen by the UART TX peripheral.
//                   The CPU side is the master, the peripheral the slave.
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_mmio_if;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output re, output addr, output wdata, input rdata);
  modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with first-word-fall-through read port.
//             Wrapping pointers plus a separate occupancy counter; a push
//             into a full FIFO is rejected even if a pop happens that cycle.
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push_i,
  input  wire logic             pop_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  output      logic [WIDTH-1:0] rdata_o,
  output      logic             full_o,
  output      logic             empty_o
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio : memory-mapped 8N1 UART transmitter. Register file (DATA,
//                STATUS, DIV) on the data-memory bus, byte FIFO, and a
//                bit-serial engine driving the registered tx line.
// Revision     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_mmio
  import mips_pkg::*;
#(
  parameter int unsigned DIVISOR    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  wire logic      clk,
  input  wire logic      reset,
  uart_tx_mmio_if.slave  bus,
  output      logic      tx,
  output      logic      irq
);

  localparam logic [15:0] DIV_RST = div_sanitize(16'(DIVISOR));

  // FIFO interface
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  // Register file state
  logic        overflow_q, overflow_d;
  logic        txie_q, txie_d;
  logic [15:0] div_q, div_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [31:0] status_word;

  // Bit engine state
  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  idx_q;
  logic [15:0] cnt_q;
  logic [15:0] div_lat_q;
  logic        tx_q;
  logic        bit_last;
  logic        busy;

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:16];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (bus.wdata[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy      = (state_q != TX_IDLE);
  assign bit_last  = (cnt_q == div_lat_q - 16'd1);
  assign fifo_push = bus.we && (bus.addr == ADDR_DATA) && !fifo_full;
  // Pop from IDLE, or at the end of a stop bit so frames run back to back
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_last));

  assign tx        = tx_q;
  assign irq       = irq_q;
  assign bus.rdata = rdata_q;

  // STATUS snapshot, always the pre-write view of this cycle
  always_comb begin
    status_word           = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = busy;
    status_word[ST_OVF]   = overflow_q;
    status_word[ST_TXIE]  = txie_q;
  end

  // Register-file next state: bus writes, read mux and interrupt level
  always_comb begin
    overflow_d = overflow_q;
    txie_d     = txie_q;
    div_d      = div_q;
    rdata_d    = rdata_q;
    if (bus.we) begin
      case (bus.addr)
        ADDR_DATA:   if (fifo_full) overflow_d = 1'b1;
        ADDR_STATUS: begin
          if (bus.wdata[ST_OVF]) overflow_d = 1'b0;
          txie_d = bus.wdata[ST_TXIE];
        end
        ADDR_DIV:    div_d = div_sanitize(bus.wdata[15:0]);
        default:     ;
      endcase
    end
    if (bus.re) begin
      case (bus.addr)
        ADDR_STATUS: rdata_d = status_word;
        ADDR_DIV:    rdata_d = {16'd0, div_q};
        default:     rdata_d = '0;
      endcase
    end
    irq_d = overflow_q | (txie_q & fifo_empty & ~busy);
  end

  // Register-file storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      txie_q     <= 1'b0;
      div_q      <= DIV_RST;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      txie_q     <= txie_d;
      div_q      <= div_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  // Bit engine: start, eight data bits LSB first, stop, each div_lat cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      div_lat_q <= DIV_RST;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q   <= fifo_rdata;
            div_lat_q <= div_q;
            cnt_q     <= '0;
            state_q   <= TX_START;
            tx_q      <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_last) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= TX_DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_last) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= TX_STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_last) begin
            cnt_q <= '0;
            if (!fifo_empty) begin
              shift_q   <= fifo_rdata;
              div_lat_q <= div_q;
              state_q   <= TX_START;
              tx_q      <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_mmio : self-checking bench for uart_tx_mmio. Bytes written to
//                   DATA are queued with the divisor they should be sent at;
//                   a line monitor decodes every frame cycle by cycle and
//                   compares against the queue head.
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_mmio;
  import mips_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  logic clk;
  logic reset;
  logic tx;
  logic irq;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(
    .DIVISOR    (868),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .tx    (tx),
    .irq   (irq)
  );

  exp_t sb_q [$];
  int   start_cyc [$];
  int   end_cyc [$];
  int   frames_seen = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   last_wr_cyc = 0;
  logic mon_en      = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.we   = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus_if.re   = 1'b1;
    bus_if.addr = a;
    @(negedge clk);
    bus_if.re = 1'b0;
    d = bus_if.rdata;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] d);
    bus_if.we    = 1'b1;
    bus_if.re    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = wd;
    @(negedge clk);
    bus_if.we = 1'b0;
    bus_if.re = 1'b0;
    d = bus_if.rdata;
  endtask

  task automatic push_byte(input logic [7:0] b, input int div);
    exp_t e;
    e.data = b;
    e.div  = div;
    sb_q.push_back(e);
    wr(ADDR_DATA, {24'd0, b});
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_seen < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_wait_timeout", 32'(frames_seen >= n), 32'd1);
  endtask

  // Line monitor: decode each frame sample by sample against the queue head
  initial begin : monitor
    exp_t       e;
    logic [9:0] fr;
    logic       v, bitv, stable;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          e.data = 8'h00;
          e.div  = 1;
        end else begin
          e = sb_q.pop_front();
        end
        fr     = '0;
        stable = 1'b1;
        bitv   = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < e.div; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            v = tx;
            if (k == 0) bitv = v;
            else if (v !== bitv) stable = 1'b0;
          end
          fr[b] = bitv;
        end
        end_cyc.push_back(cyc);
        check("frame_bits", 32'(fr), 32'({1'b1, e.data, 1'b0}));
        check("bit_width", 32'(stable), 32'd1);
        frames_seen++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int base;
    reset        = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.re    = 1'b0;
    bus_if.addr  = 2'd0;
    bus_if.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", bus_if.rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a frame
    wr(ADDR_DIV, 32'd4);
    wr(ADDR_DATA, 32'h3C);
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("rst_mid_tx", 32'(tx), 32'd1);
    @(negedge clk);
    check("rst_mid_rdata", bus_if.rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    rd(ADDR_STATUS, d); check("rst_status", d, 32'h2);
    rd(ADDR_DIV, d);    check("rst_div", d, 32'd868);
    rd(ADDR_DATA, d);   check("data_read_zero", d, 32'd0);
    wr(ADDR_RSVD, 32'hFFFF);
    rd(ADDR_RSVD, d);   check("rsvd_read_zero", d, 32'd0);
    rd(ADDR_DIV, d);    check("rsvd_write_ignored", d, 32'd868);
    mon_en = 1'b1;

    // Single byte at DIV=4, start-bit latency
    wr(ADDR_DIV, 32'd4);
    base = frames_seen;
    push_byte(8'h55, 4);
    d = 32'(last_wr_cyc);
    repeat (5) @(negedge clk);
    begin
      logic [31:0] s;
      rd(ADDR_STATUS, s); check("busy_status", s, 32'h6);
    end
    wait_frames(base + 1, 100);
    check("start_latency", 32'(start_cyc[base]) - d, 32'd1);
    repeat (2) @(negedge clk);
    rd(ADDR_STATUS, d); check("idle_status", d, 32'h2);

    // Overflow at DIV=2
    wr(ADDR_DIV, 32'd2);
    base = frames_seen;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) push_byte(8'h30 + 8'(i), 2);
      else wr(ADDR_DATA, 32'h39);
    end
    rd(ADDR_STATUS, d); check("ovf_status", d, 32'hD);
    check("ovf_irq", 32'(irq), 32'd1);
    wr(ADDR_STATUS, 32'h8);
    @(negedge clk);
    check("ovf_irq_clear", 32'(irq), 32'd0);
    rd(ADDR_STATUS, d); check("ovf_cleared_status", d, 32'h5);
    wait_frames(base + 9, 9 * 20 + 50);

    // Three contiguous frames at DIV=3
    repeat (3) @(negedge clk);
    wr(ADDR_DIV, 32'd3);
    base = frames_seen;
    push_byte(8'hA5, 3);
    push_byte(8'h00, 3);
    push_byte(8'hFF, 3);
    wait_frames(base + 3, 200);
    check("contig_gap1", 32'(start_cyc[base+1] - start_cyc[base]), 32'd30);
    check("contig_gap2", 32'(start_cyc[base+2] - start_cyc[base+1]), 32'd30);
    check("contig_total", 32'(end_cyc[base+2] - start_cyc[base] + 1), 32'd90);

    // Divisor change during a frame
    repeat (3) @(negedge clk);
    wr(ADDR_DIV, 32'd4);
    base = frames_seen;
    push_byte(8'h96, 4);
    repeat (8) @(negedge clk);
    wr(ADDR_DIV, 32'd8);
    push_byte(8'h69, 8);
    wait_frames(base + 2, 400);
    check("divchg_first_len", 32'(start_cyc[base+1] - start_cyc[base]), 32'd40);
    check("divchg_second_len", 32'(end_cyc[base+1] - start_cyc[base+1] + 1), 32'd80);

    // Interrupt on transmitter going idle with txie
    repeat (3) @(negedge clk);
    wr(ADDR_DIV, 32'd1);
    rdwr(ADDR_STATUS, 32'h10, d); check("rw_pre_write", d, 32'h2);
    rd(ADDR_STATUS, d);           check("txie_status", d, 32'h12);
    check("txie_irq_idle", 32'(irq), 32'd1);
    base = frames_seen;
    push_byte(8'hC3, 1);
    repeat (11) @(negedge clk);
    check("irq_before_idle", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_after_idle", 32'(irq), 32'd1);
    wait_frames(base + 1, 50);
    wr(ADDR_STATUS, 32'h0);
    repeat (2) @(negedge clk);
    check("txie_off_irq", 32'(irq), 32'd0);
    wr(ADDR_DIV, 32'd0);
    rd(ADDR_DIV, d); check("div_zero_as_one", d, 32'd1);
    repeat (3) @(negedge clk);
    check("rdata_hold", bus_if.rdata, 32'd1);
    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
